pitch_frame_scheduler: RTL and testbench

- Sequences the f0 estimator over repeated audio frames.
- Captures N_SAMPLES ADC samples into the shared 2048x12 sample RAM, then hands RAM read ownership to the estimator and pulses its start.
- Waits for the estimator's done handshake, then selects the winning note from the five 36-bit sums.
- Publishes the result to the display/LED logic, then starts the next frame while run is high.

---
 rtl/pitch_frame_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_pitch_frame_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pitch_frame_scheduler.sv
// pitch_frame_scheduler: frame sequencer around the f0 estimator.
// Captures N_SAMPLES ADC samples into the shared sample RAM, then hands
// RAM read ownership to the estimator, waits for its done handshake,
// picks the winning note from five 36-bit sums and publishes it.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   run                 level, keep sequencing frames while high
//   sample_valid/_in    ADC sample strobe and 12-bit data
//   est_addr            estimator RAM read address
//   mem_we/addr/wdata   shared RAM port (capture owns it only in CAPTURE)
//   est_start/est_done  estimator start pulse / done level
//   sum_c..sum_a        estimator per-note sums
//   note_out/note_valid winning note (0=C 1=D 2=E 3=G 4=A) and update pulse
//   busy                high in every state except IDLE
//   err_timeout         sticky watchdog flag
// Optional: define WATCHDOG_EN to enable the WAIT_LO/WAIT_HI watchdog.
module pitch_frame_scheduler #(
    parameter int N_SAMPLES      = 2048,
    parameter bit SELECT_MAX     = 1'b0,
    parameter int TIMEOUT_CYCLES = 32768
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        sample_valid,
    input  logic [11:0] sample_in,
    input  logic [10:0] est_addr,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [11:0] mem_wdata,
    output logic        est_start,
    input  logic        est_done,
    input  logic [35:0] sum_c,
    input  logic [35:0] sum_d,
    input  logic [35:0] sum_e,
    input  logic [35:0] sum_g,
    input  logic [35:0] sum_a,
    output logic [2:0]  note_out,
    output logic        note_valid,
    output logic        busy,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_COMPARE,
        S_REPORT
    } state_t;

    localparam logic [10:0] LAST_PTR = 11'(N_SAMPLES - 1);

    state_t      state_q, state_d;
    logic [10:0] wr_ptr_q, wr_ptr_d;
    logic [2:0]  cmp_q, cmp_d;
    logic [35:0] best_q, best_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  note_q, note_d;
    logic [35:0] cur_sum;
    logic        better;
    logic        wd_hit;
    logic        lock_q;

`ifdef WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_q, wd_d;
    logic        err_q, err_d;
    logic        lock_d;

    assign wd_hit      = (wd_q == WD_LAST);
    assign err_timeout = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q   <= '0;
            err_q  <= 1'b0;
            lock_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            err_q  <= err_d;
            lock_q <= lock_d;
        end
    end

    // lock_q blocks restart after a timeout until run is seen low in IDLE.
    always_comb begin
        wd_d   = wd_q;
        err_d  = err_q;
        lock_d = lock_q;
        if (state_q == S_START) begin
            wd_d = '0;
        end else if (state_q == S_WAIT_LO || state_q == S_WAIT_HI) begin
            if (wd_hit) begin
                err_d  = 1'b1;
                lock_d = 1'b1;
            end else begin
                wd_d = wd_q + 16'd1;
            end
        end
        if (state_q == S_IDLE && !run) begin
            lock_d = 1'b0;
        end
    end
`else
    assign wd_hit      = 1'b0;
    assign lock_q      = 1'b0;
    // TIMEOUT_CYCLES has no role without the watchdog; this folds to 0.
    assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        unique case (cmp_q)
            3'd0:    cur_sum = sum_c;
            3'd1:    cur_sum = sum_d;
            3'd2:    cur_sum = sum_e;
            3'd3:    cur_sum = sum_g;
            default: cur_sum = sum_a;
        endcase
    end

    // Strict comparison so ties keep the earlier (lower) note index.
    assign better = SELECT_MAX ? (cur_sum > best_q) : (cur_sum < best_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            cmp_q    <= '0;
            best_q   <= '0;
            idx_q    <= '0;
            note_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            cmp_q    <= cmp_d;
            best_q   <= best_d;
            idx_q    <= idx_d;
            note_q   <= note_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cmp_d      = cmp_q;
        best_d     = best_q;
        idx_d      = idx_q;
        note_d     = note_q;
        mem_we     = 1'b0;
        mem_addr   = est_addr;
        mem_wdata  = sample_in;
        est_start  = 1'b0;
        note_valid = 1'b0;
        note_out   = note_q;
        busy       = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                wr_ptr_d = '0;
                if (run && !lock_q) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                mem_we   = sample_valid;
                mem_addr = wr_ptr_q;
                if (!run) begin
                    state_d = S_IDLE;
                end else if (sample_valid) begin
                    wr_ptr_d = wr_ptr_q + 11'd1;
                    if (wr_ptr_q == LAST_PTR) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                est_start = 1'b1;
                state_d   = S_WAIT_LO;
            end
            // est_done idles high, so first wait for the estimator to drop it.
            S_WAIT_LO: begin
                if (wd_hit) begin
                    state_d = S_IDLE;
                end else if (!est_done) begin
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                cmp_d = '0;
                if (wd_hit) begin
                    state_d = S_IDLE;
                end else if (est_done) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (cmp_q == 3'd0 || better) begin
                    best_d = cur_sum;
                    idx_d  = cmp_q;
                end
                if (cmp_q == 3'd4) begin
                    state_d = S_REPORT;
                end else begin
                    cmp_d = cmp_q + 3'd1;
                end
            end
            S_REPORT: begin
                note_valid = 1'b1;
                note_out   = idx_q;
                note_d     = idx_q;
                wr_ptr_d   = '0;
                state_d    = run ? S_CAPTURE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pitch_frame_scheduler.sv
// tb_pitch_frame_scheduler: randomized scoreboard bench for the frame
// scheduler, with a min-select and a max-select instance side by side.
module tb_pitch_frame_scheduler;

    localparam int NS  = 256;
    localparam int TMO = 50;

    typedef struct packed {
        int         c;
        logic [2:0] mn;
        logic [2:0] mx;
    } note_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample_in = '0;
    logic [10:0] est_addr = '0;
    logic        est_done = 1'b1;
    logic [35:0] sums [5];

    logic [1:0]  mem_we;
    logic [1:0]  est_start;
    logic [1:0]  note_valid;
    logic [1:0]  busy;
    logic [1:0]  err_timeout;
    logic [10:0] mem_addr [2];
    logic [11:0] mem_wdata [2];
    logic [2:0]  note_out [2];

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          err_cyc = 32'h7fffffff;
    bit          own_est = 1'b0;
    logic [2:0]  last_note [2];

    logic [22:0] exp_wr [$];
    int          exp_st [$];
    note_t       exp_nt [$];
    int          wr_rd [2];
    int          st_rd [2];
    int          nt_rd [2];

    pitch_frame_scheduler #(
        .N_SAMPLES(NS), .SELECT_MAX(1'b0), .TIMEOUT_CYCLES(TMO)
    ) u_min (
        .clk(clk), .rst_n(rst_n), .run(run),
        .sample_valid(sample_valid), .sample_in(sample_in),
        .est_addr(est_addr), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .est_start(est_start[0]), .est_done(est_done),
        .sum_c(sums[0]), .sum_d(sums[1]), .sum_e(sums[2]),
        .sum_g(sums[3]), .sum_a(sums[4]),
        .note_out(note_out[0]), .note_valid(note_valid[0]),
        .busy(busy[0]), .err_timeout(err_timeout[0])
    );

    pitch_frame_scheduler #(
        .N_SAMPLES(NS), .SELECT_MAX(1'b1), .TIMEOUT_CYCLES(TMO)
    ) u_max (
        .clk(clk), .rst_n(rst_n), .run(run),
        .sample_valid(sample_valid), .sample_in(sample_in),
        .est_addr(est_addr), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .est_start(est_start[1]), .est_done(est_done),
        .sum_c(sums[0]), .sum_d(sums[1]), .sum_e(sums[2]),
        .sum_g(sums[3]), .sum_a(sums[4]),
        .note_out(note_out[1]), .note_valid(note_valid[1]),
        .busy(busy[1]), .err_timeout(err_timeout[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic void fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event seen with nothing expected (cycle %0d)",
                 name, cyc);
    endfunction

    // Monitor: pops expectations whenever a DUT presents an output.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (mem_we[d]) begin
                    if (wr_rd[d] < exp_wr.size()) begin
                        chk("wr_addr", 64'(mem_addr[d]),
                            64'(exp_wr[wr_rd[d]][22:12]));
                        chk("wr_data", 64'(mem_wdata[d]),
                            64'(exp_wr[wr_rd[d]][11:0]));
                        wr_rd[d]++;
                    end else begin
                        fail("unexpected_write");
                    end
                end else if (own_est) begin
                    chk("addr_mux", 64'(mem_addr[d]), 64'(est_addr));
                end
                if (est_start[d]) begin
                    if (st_rd[d] < exp_st.size()) begin
                        chk("start_cycle", 64'(cyc), 64'(exp_st[st_rd[d]]));
                        st_rd[d]++;
                    end else begin
                        fail("unexpected_start");
                    end
                end
                if (note_valid[d]) begin
                    if (nt_rd[d] < exp_nt.size()) begin
                        last_note[d] = (d == 1) ? exp_nt[nt_rd[d]].mx
                                                : exp_nt[nt_rd[d]].mn;
                        chk("note_cycle", 64'(cyc), 64'(exp_nt[nt_rd[d]].c));
                        chk("note", 64'(note_out[d]), 64'(last_note[d]));
                        nt_rd[d]++;
                    end else begin
                        fail("unexpected_note");
                    end
                end else begin
                    chk("note_hold", 64'(note_out[d]), 64'(last_note[d]));
                end
                chk("err_timeout", 64'(err_timeout[d]), 64'(cyc >= err_cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bus();
        sample_valid = 1'($urandom_range(0, 1));
        sample_in    = 12'($urandom);
        est_addr     = 11'($urandom);
    endtask

    // Reference pick: find extreme value, then lowest index holding it.
    function automatic void ref_pick(output logic [2:0] mn,
                                     output logic [2:0] mx);
        logic [35:0] lo;
        logic [35:0] hi;
        lo = sums[0];
        hi = sums[0];
        for (int i = 1; i < 5; i++) begin
            if (sums[i] < lo) lo = sums[i];
            if (sums[i] > hi) hi = sums[i];
        end
        mn = 3'd0;
        mx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (sums[i] == lo) mn = 3'(i);
            if (sums[i] == hi) mx = 3'(i);
        end
    endfunction

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                sample_valid = 1'b0;
                tick();
            end
            sample_valid = 1'b1;
            sample_in    = 12'($urandom);
            est_addr     = 11'($urandom);
            exp_wr.push_back({11'(i), sample_in});
            if (i == NS - 1) exp_st.push_back(cyc + 1);
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic wait_start();
        int t;
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (est_start[0]) break;
        end
        if (t == 20) fail("start_timeout");
    endtask

    task automatic estimate(input int mode, input bit drop_run);
        int t;
        logic [2:0] mn;
        logic [2:0] mx;
        tick();
        own_est = 1'b1;
        if (drop_run) run = 1'b0;
        repeat ($urandom_range(1, 4)) begin
            rand_bus();
            tick();
        end
        est_done = 1'b0;
        repeat ($urandom_range(1, 20)) begin
            rand_bus();
            tick();
        end
        if (mode == 0) begin
            sums[0] = 36'd500;
            sums[1] = 36'd300;
            sums[2] = 36'd300;
            sums[3] = 36'd900;
            sums[4] = 36'd400;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (mode == 1) sums[i] = 36'($urandom_range(0, 3));
                else sums[i] = {4'($urandom), 32'($urandom)};
            end
        end
        ref_pick(mn, mx);
        est_done = 1'b1;
        exp_nt.push_back('{c: cyc + 6, mn: mn, mx: mx});
        for (t = 0; t < 20; t++) begin
            rand_bus();
            @(negedge clk);
            if (note_valid[0]) break;
            @(posedge clk);
            #1;
        end
        if (t == 20) fail("note_timeout");
        @(posedge clk);
        #1;
        own_est      = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_busy"}, 64'(busy[d]), 64'd0);
            chk({tag, "_start"}, 64'(est_start[d]), 64'd0);
            chk({tag, "_nvalid"}, 64'(note_valid[d]), 64'd0);
            chk({tag, "_note"}, 64'(note_out[d]), 64'd0);
            chk({tag, "_we"}, 64'(mem_we[d]), 64'd0);
            chk({tag, "_err"}, 64'(err_timeout[d]), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 5; i++) sums[i] = '0;
        last_note[0] = 3'd0;
        last_note[1] = 3'd0;
        for (int d = 0; d < 2; d++) begin
            wr_rd[d] = 0;
            st_rd[d] = 0;
            nt_rd[d] = 0;
        end
        repeat (3) tick();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);

        run = 1'b1;
        tick();
        chk("capture_busy", 64'(busy), 64'b11);
        capture(NS);
        wait_start();
        estimate(0, 1'b0);
        for (int f = 1; f < 5; f++) begin
            capture(NS);
            wait_start();
            estimate(f % 2 + 1, 1'b0);
        end

        // Abort mid-capture, then restart from address 0.
        capture(NS / 2);
        run = 1'b0;
        tick();
        repeat (3) tick();
        chk("abort_busy", 64'(busy), 64'd0);
        run = 1'b1;
        tick();
        capture(NS);
        wait_start();
        estimate(1, 1'b1);
        tick();
        chk("drop_run_busy", 64'(busy), 64'd0);

        // Reset while waiting for done to rise.
        run = 1'b1;
        tick();
        capture(NS);
        wait_start();
        tick();
        own_est  = 1'b1;
        est_done = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        last_note[0] = 3'd0;
        last_note[1] = 3'd0;
        own_est  = 1'b0;
        est_done = 1'b1;
        run      = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run = 1'b1;
        tick();
        capture(NS);
        wait_start();
        estimate(2, 1'b0);

`ifdef WATCHDOG_EN
        capture(NS);
        wait_start();
        err_cyc = cyc + 1 + TMO;
        tick();
        own_est = 1'b1;
        repeat (TMO + 5) begin
            rand_bus();
            tick();
        end
        sample_valid = 1'b0;
        chk("wd_idle_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        chk("wd_locked_busy", 64'(busy), 64'd0);
        own_est = 1'b0;
        run = 1'b0;
        repeat (2) tick();
        run = 1'b1;
        repeat (2) tick();
        chk("wd_restart_busy", 64'(busy), 64'b11);
        run = 1'b0;
        repeat (2) tick();
`endif

        run = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk("writes_drained", 64'(wr_rd[d]), 64'(exp_wr.size()));
            chk("starts_drained", 64'(st_rd[d]), 64'(exp_st.size()));
            chk("notes_drained", 64'(nt_rd[d]), 64'(exp_nt.size()));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
